// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the push-button conditioner.
//   key_state_t  : per-key debounce/hold/repeat state
//   CLK_HZ       : board system clock frequency
//   ms_to_cycles : converts a duration in milliseconds to clock cycles
package key_cond_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    REPEAT,
    DEB_RELEASE
  } key_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_conditioner_fsm.sv
// One key channel: 2-flop synchroniser, debounce/hold/repeat FSM and its counter.
// The input is already polarity-normalised (1 = pressed).
//   clk_i      : system clock
//   rst_i      : asynchronous reset, active high
//   key_i      : raw asynchronous key, 1 = pressed
//   level_o    : debounced pressed level
//   press_o    : 1-cycle strobe on accepted press
//   release_o  : 1-cycle strobe on accepted release
//   long_o     : 1-cycle strobe when the hold time is reached
//   repeat_o   : 1-cycle strobe at long-press and every REPEAT_CYCLES after
module key_fsm
  import key_cond_pkg::*;
#(
  parameter int DB_CYCLES     = 500_000,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             p;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  assign p = sync_q[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  // The synchroniser resets to the released level (0) so no spurious press is
  // seen while the pins settle after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (p) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!p) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_TC) begin
          state_d  = REPEAT;
          cnt_d    = '0;
          long_d   = 1'b1;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!p) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == REP_TC) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DEB_RELEASE: begin
        // A bounce back to pressed returns to PRESSED and restarts hold timing.
        if (p) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level follows the state being entered so it changes on the same edge as
    // the press/release strobe.
    level_d = (state_d == PRESSED) || (state_d == REPEAT) || (state_d == DEB_RELEASE);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner for the DE10-Lite keys: normalises key polarity and
// instantiates one independent key_fsm channel per key.
//   MAX10_CLK1_50 : 50 MHz system clock
//   RST           : asynchronous reset, active high
//   KEY_IN        : raw key pins
//   KEY_LEVEL     : debounced pressed level per key (1 = pressed)
//   KEY_PRESS     : 1-cycle press strobe per key
//   KEY_RELEASE   : 1-cycle release strobe per key
//   KEY_LONG      : 1-cycle long-press strobe per key
//   KEY_REPEAT    : 1-cycle auto-repeat strobe per key
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS         = 2,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int DB_CYCLES      = int'(ms_to_cycles(CLK_HZ, 10)),
  parameter int HOLD_CYCLES    = int'(ms_to_cycles(CLK_HZ, 500)),
  parameter int REPEAT_CYCLES  = int'(ms_to_cycles(CLK_HZ, 100))
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY_IN,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic [N_KEYS-1:0] KEY_LONG,
  output logic [N_KEYS-1:0] KEY_REPEAT
);

  // Inverting ahead of the synchroniser is equivalent to inverting after it,
  // and lets the synchroniser reset to 0 as the released level.
  logic [N_KEYS-1:0] key_p;
  assign key_p = KEY_ACTIVE_LOW ? ~KEY_IN : KEY_IN;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_fsm #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_fsm (
      .clk_i    (MAX10_CLK1_50),
      .rst_i    (RST),
      .key_i    (key_p[g]),
      .level_o  (KEY_LEVEL[g]),
      .press_o  (KEY_PRESS[g]),
      .release_o(KEY_RELEASE[g]),
      .long_o   (KEY_LONG[g]),
      .repeat_o (KEY_REPEAT[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DB=4, HOLD=20, REPEAT=5, two keys.
// Stimulus pushes expected strobe events {cycle, key, strobes, level}; a monitor
// on the falling edge pops one entry for every key that shows any strobe.
module tb_key_conditioner;

  logic       clk;
  logic       RST;
  logic [1:0] KEY_IN;
  logic [1:0] KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_LONG, KEY_REPEAT;

  key_conditioner #(
    .N_KEYS        (2),
    .KEY_ACTIVE_LOW(1'b1),
    .DB_CYCLES     (4),
    .HOLD_CYCLES   (20),
    .REPEAT_CYCLES (5)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RST          (RST),
    .KEY_IN       (KEY_IN),
    .KEY_LEVEL    (KEY_LEVEL),
    .KEY_PRESS    (KEY_PRESS),
    .KEY_RELEASE  (KEY_RELEASE),
    .KEY_LONG     (KEY_LONG),
    .KEY_REPEAT   (KEY_REPEAT)
  );

  // strb = {press, release, long, repeat}
  typedef struct {
    int         cyc;
    int         key;
    logic [3:0] strb;
    logic       lvl;
  } ev_t;

  localparam logic [3:0] S_PRESS = 4'b1000;
  localparam logic [3:0] S_REL   = 4'b0100;
  localparam logic [3:0] S_LR    = 4'b0011;
  localparam logic [3:0] S_REP   = 4'b0001;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops and compares one expected event per strobing key.
  logic [3:0] mon_s;
  ev_t        mon_e;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mon_s = {KEY_PRESS[k], KEY_RELEASE[k], KEY_LONG[k], KEY_REPEAT[k]};
      if (mon_s != 4'b0000) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: cycle %0d key %0d strobes %b level %b, required none",
                   cyc, k, mon_s, KEY_LEVEL[k]);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.key != k || mon_e.strb != mon_s ||
              mon_e.lvl != KEY_LEVEL[k]) begin
            n_err++;
            $display("FAIL event: got cycle %0d key %0d strobes %b level %b, required cycle %0d key %0d strobes %b level %b",
                     cyc, k, mon_s, KEY_LEVEL[k], mon_e.cyc, mon_e.key, mon_e.strb, mon_e.lvl);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input int k, input logic [3:0] s, input logic l);
    ev_t e;
    e.cyc  = c;
    e.key  = k;
    e.strb = s;
    e.lvl  = l;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Every expected event of a test must have been consumed by its end.
  task automatic drain(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int t;
    int r;

    // 1: reset with both keys held, then a new press after reset release.
    KEY_IN = 2'b00;
    RST    = 1'b1;
    tick(5);
    check("rst_outputs", 32'({KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_LONG, KEY_REPEAT}), 32'd0);
    RST = 1'b0;
    t   = cyc;
    expect_ev(t + 7, 0, S_PRESS, 1'b1);
    expect_ev(t + 7, 1, S_PRESS, 1'b1);
    tick(6);
    check("t1_level_before", 32'(KEY_LEVEL), 32'd0);
    tick(1);
    check("t1_level_after", 32'(KEY_LEVEL), 32'd3);
    KEY_IN = 2'b11;
    expect_ev(t + 14, 0, S_REL, 1'b0);
    expect_ev(t + 14, 1, S_REL, 1'b0);
    tick(12);
    drain("t1_pending");
    check("t1_level_end", 32'(KEY_LEVEL), 32'd0);

    // 2: 3-cycle glitch on key 0 is rejected.
    KEY_IN[0] = 1'b0;
    tick(3);
    KEY_IN[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("t2_level0", 32'(KEY_LEVEL[0]), 32'd0);
    end
    drain("t2_pending");

    // 3: press, then release with bounce; a single press and a single release.
    t = cyc;
    KEY_IN[0] = 1'b0;
    expect_ev(t + 7, 0, S_PRESS, 1'b1);
    tick(10);
    KEY_IN[0] = 1'b1; tick(1);
    KEY_IN[0] = 1'b0; tick(1);
    KEY_IN[0] = 1'b1; tick(2);
    KEY_IN[0] = 1'b0; tick(2);
    KEY_IN[0] = 1'b1;
    r = cyc;
    expect_ev(r + 7, 0, S_REL, 1'b0);
    tick(12);
    drain("t3_pending");

    // 4: long hold on key 1: long+repeat at t+27, repeats every 5, then release.
    t = cyc;
    KEY_IN[1] = 1'b0;
    expect_ev(t + 7, 1, S_PRESS, 1'b1);
    expect_ev(t + 27, 1, S_LR, 1'b1);
    for (int c = t + 32; c <= t + 62; c += 5) expect_ev(c, 1, S_REP, 1'b1);
    tick(60);
    check("t4_level_held", 32'(KEY_LEVEL), 32'd2);
    KEY_IN[1] = 1'b1;
    expect_ev(t + 67, 1, S_REL, 1'b0);
    tick(12);
    drain("t4_pending");

    // 5: both keys pressed together, released 10 cycles apart.
    t = cyc;
    KEY_IN = 2'b00;
    expect_ev(t + 7, 0, S_PRESS, 1'b1);
    expect_ev(t + 7, 1, S_PRESS, 1'b1);
    tick(10);
    KEY_IN[0] = 1'b1;
    expect_ev(t + 17, 0, S_REL, 1'b0);
    tick(10);
    KEY_IN[1] = 1'b1;
    expect_ev(t + 27, 1, S_REL, 1'b0);
    tick(12);
    drain("t5_pending");

    // 6: reset while key 0 is auto-repeating: outputs clear, no release strobe.
    t = cyc;
    KEY_IN[0] = 1'b0;
    expect_ev(t + 7, 0, S_PRESS, 1'b1);
    expect_ev(t + 27, 0, S_LR, 1'b1);
    expect_ev(t + 32, 0, S_REP, 1'b1);
    tick(34);
    check("t6_level_pre", 32'(KEY_LEVEL), 32'd1);
    RST = 1'b1;
    @(negedge clk);
    check("t6_rst_outputs", 32'({KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_LONG, KEY_REPEAT}), 32'd0);
    KEY_IN[0] = 1'b1;
    tick(5);
    RST = 1'b0;
    tick(15);
    drain("t6_pending");
    check("t6_level_end", 32'(KEY_LEVEL), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
